// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

  // Arbiter transaction state: idle or waiting on the in-flight response.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_D  = 2'd2
  } arb_state_t;

  // Request payload presented to memory; the grant mux is one struct copy.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_MASK_W-1:0] wmask;
  } mem_req_t;

  // Saturating increment for the fetch-starvation counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] max_val);
    sat_inc = (val >= max_val) ? max_val : 8'(val + 8'd1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight; data has priority, bounded by a fetch-starvation
// guard; fetch responses made stale by a flush are dropped.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = MEM_ADDR_W,
  parameter int unsigned DATA_WIDTH      = MEM_DATA_W,
  parameter int unsigned MAX_DATA_GRANTS = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  // instruction fetch requester
  input  logic                    ifetch_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   ifetch_req_addr_i,
  output logic                    ifetch_req_ready_o,
  input  logic                    ifetch_flush_i,
  output logic                    ifetch_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   ifetch_resp_data_o,
  // load/store requester
  input  logic                    dmem_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   dmem_req_addr_i,
  input  logic                    dmem_req_we_i,
  input  logic [DATA_WIDTH-1:0]   dmem_req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_req_wmask_i,
  output logic                    dmem_req_ready_o,
  output logic                    dmem_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   dmem_resp_data_o,
  // memory interface
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
  output logic                    mem_req_we_o,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask_o,
  input  logic                    mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data_i
);

  localparam int unsigned CNT_W = 8;

  // Elaboration checks on parameters.
  if (MAX_DATA_GRANTS < 1 || MAX_DATA_GRANTS > 255) begin : g_chk_max_grants
    $error("mem_port_arbiter: MAX_DATA_GRANTS must be in 1..255");
  end
  if (ADDR_WIDTH != MEM_ADDR_W || DATA_WIDTH != MEM_DATA_W) begin : g_chk_widths
    $error("mem_port_arbiter: bus widths must match mem_port_arbiter_pkg");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_GRANTS);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             flushed_q, flushed_d;

  logic     starve_at_max;
  logic     grant_dmem;
  logic     grant_ifetch;
  mem_req_t dmem_req;
  mem_req_t ifetch_req;
  mem_req_t mem_req;

  // Requester payloads packed into the memory request format.
  always_comb begin
    dmem_req       = '0;
    dmem_req.addr  = dmem_req_addr_i;
    dmem_req.we    = dmem_req_we_i;
    dmem_req.wdata = dmem_req_wdata_i;
    dmem_req.wmask = dmem_req_wmask_i;
    ifetch_req      = '0;
    ifetch_req.addr = ifetch_req_addr_i;
  end

  // Idle grant selection: data first unless fetch has waited too long.
  always_comb begin
    starve_at_max = (starve_cnt_q == MAX_CNT);
    grant_dmem    = 1'b0;
    grant_ifetch  = 1'b0;
    if (state_q == ARB_IDLE && !reset_i) begin
      grant_dmem   = dmem_req_valid_i && !(ifetch_req_valid_i && starve_at_max);
      grant_ifetch = !grant_dmem && ifetch_req_valid_i;
    end
  end

  // Next-state, starvation/flush bookkeeping and port outputs.
  always_comb begin
    state_d             = state_q;
    starve_cnt_d        = starve_cnt_q;
    flushed_d           = flushed_q;
    mem_req             = '0;
    mem_req_valid_o     = 1'b0;
    ifetch_req_ready_o  = 1'b0;
    dmem_req_ready_o    = 1'b0;
    ifetch_resp_valid_o = 1'b0;
    ifetch_resp_data_o  = '0;
    dmem_resp_valid_o   = 1'b0;
    dmem_resp_data_o    = '0;

    case (state_q)
      ARB_IDLE: begin
        if (grant_dmem) begin
          mem_req          = dmem_req;
          mem_req_valid_o  = 1'b1;
          dmem_req_ready_o = mem_req_ready_i;
          if (mem_req_ready_i) begin
            state_d      = ARB_WAIT_D;
            starve_cnt_d = ifetch_req_valid_i ? sat_inc(starve_cnt_q, MAX_CNT) : '0;
          end
        end else if (grant_ifetch) begin
          mem_req            = ifetch_req;
          mem_req_valid_o    = 1'b1;
          ifetch_req_ready_o = mem_req_ready_i;
          if (mem_req_ready_i) begin
            state_d      = ARB_WAIT_IF;
            starve_cnt_d = '0;
            // A flush in the accept cycle already makes this fetch stale.
            flushed_d    = ifetch_flush_i;
          end
        end
      end

      ARB_WAIT_IF: begin
        if (mem_resp_valid_i) begin
          ifetch_resp_valid_o = !(flushed_q || ifetch_flush_i);
          ifetch_resp_data_o  = mem_resp_data_i;
          flushed_d           = 1'b0;
          state_d             = ARB_IDLE;
        end else if (ifetch_flush_i) begin
          flushed_d = 1'b1;
        end
      end

      ARB_WAIT_D: begin
        if (mem_resp_valid_i) begin
          dmem_resp_valid_o = 1'b1;
          dmem_resp_data_o  = mem_resp_data_i;
          state_d           = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Memory request fields from the selected payload.
  always_comb begin
    mem_req_addr_o  = mem_req.addr;
    mem_req_we_o    = mem_req.we;
    mem_req_wdata_o = mem_req.wdata;
    mem_req_wmask_o = mem_req.wmask;
  end

  // State registers; reset drops any outstanding transaction.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      flushed_q    <= flushed_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic        ifetch_req_valid_i;
  logic [31:0] ifetch_req_addr_i;
  logic        ifetch_req_ready_o;
  logic        ifetch_flush_i;
  logic        ifetch_resp_valid_o;
  logic [31:0] ifetch_resp_data_o;
  logic        dmem_req_valid_i;
  logic [31:0] dmem_req_addr_i;
  logic        dmem_req_we_i;
  logic [31:0] dmem_req_wdata_i;
  logic [3:0]  dmem_req_wmask_i;
  logic        dmem_req_ready_o;
  logic        dmem_resp_valid_o;
  logic [31:0] dmem_resp_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_we_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_wmask_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_DATA_GRANTS (4)
  ) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .ifetch_req_valid_i  (ifetch_req_valid_i),
    .ifetch_req_addr_i   (ifetch_req_addr_i),
    .ifetch_req_ready_o  (ifetch_req_ready_o),
    .ifetch_flush_i      (ifetch_flush_i),
    .ifetch_resp_valid_o (ifetch_resp_valid_o),
    .ifetch_resp_data_o  (ifetch_resp_data_o),
    .dmem_req_valid_i    (dmem_req_valid_i),
    .dmem_req_addr_i     (dmem_req_addr_i),
    .dmem_req_we_i       (dmem_req_we_i),
    .dmem_req_wdata_i    (dmem_req_wdata_i),
    .dmem_req_wmask_i    (dmem_req_wmask_i),
    .dmem_req_ready_o    (dmem_req_ready_o),
    .dmem_resp_valid_o   (dmem_resp_valid_o),
    .dmem_resp_data_o    (dmem_resp_data_o),
    .mem_req_valid_o     (mem_req_valid_o),
    .mem_req_ready_i     (mem_req_ready_i),
    .mem_req_addr_o      (mem_req_addr_o),
    .mem_req_we_o        (mem_req_we_o),
    .mem_req_wdata_o     (mem_req_wdata_o),
    .mem_req_wmask_o     (mem_req_wmask_o),
    .mem_resp_valid_i    (mem_resp_valid_i),
    .mem_resp_data_i     (mem_resp_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_reqs();
    ifetch_req_valid_i = 1'b0;
    ifetch_req_addr_i  = '0;
    ifetch_flush_i     = 1'b0;
    dmem_req_valid_i   = 1'b0;
    dmem_req_addr_i    = '0;
    dmem_req_we_i      = 1'b0;
    dmem_req_wdata_i   = '0;
    dmem_req_wmask_i   = '0;
  endtask

  // Idle-state grant vectors, applied with starve count below the limit.
  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        dv;
    logic [31:0] da;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        rdy;
    logic        mv;
    logic [31:0] ma;
    logic        mwe;
    logic [31:0] mwd;
    logic [3:0]  mwm;
    logic        ifr;
    logic        dr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // order: ifv ifa dv da we wd wm rdy | mv ma mwe mwd mwm ifr dr
    vecs[0] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,        4'h0, 1'b1,
                1'b0, 32'h0,  1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 32'h0,        4'h0, 1'b0,
                1'b1, 32'h10, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 32'h0,        4'h0, 1'b1,
                1'b1, 32'h14, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 32'h12345678, 4'hF, 1'b0,
                1'b1, 32'h20, 1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 32'h24, 1'b0, 32'hAAAA5555, 4'h0, 1'b1,
                1'b1, 32'h24, 1'b0, 32'hAAAA5555, 4'h0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h30, 1'b1, 32'h34, 1'b1, 32'hCAFEF00D, 4'h5, 1'b0,
                1'b1, 32'h34, 1'b1, 32'hCAFEF00D, 4'h5, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h30, 1'b1, 32'h34, 1'b1, 32'hCAFEF00D, 4'h5, 1'b1,
                1'b1, 32'h34, 1'b1, 32'hCAFEF00D, 4'h5, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'h38, 1'b0, 32'h0,  1'b0, 32'h0,        4'h0, 1'b1,
                1'b1, 32'h38, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0};
  end

  initial begin
    logic exp_fetch;

    // Reset: outputs held at zero even with both requesters active.
    reset_i          = 1'b1;
    clear_reqs();
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    ifetch_req_valid_i = 1'b1;
    dmem_req_valid_i   = 1'b1;
    dmem_req_addr_i    = 32'h50;
    #2;
    check("rst_mem_valid", mem_req_valid_o, 0);
    check("rst_if_ready", ifetch_req_ready_o, 0);
    check("rst_d_ready", dmem_req_ready_o, 0);
    check("rst_mem_addr", mem_req_addr_o, 0);
    check("rst_if_resp", ifetch_resp_valid_o, 0);
    check("rst_d_resp", dmem_resp_valid_o, 0);
    clear_reqs();
    step();
    step();
    reset_i = 1'b0;

    // Table of idle grant vectors; accepted ones are completed and routed.
    foreach (vecs[i]) begin
      step();
      ifetch_req_valid_i = vecs[i].ifv;
      ifetch_req_addr_i  = vecs[i].ifa;
      dmem_req_valid_i   = vecs[i].dv;
      dmem_req_addr_i    = vecs[i].da;
      dmem_req_we_i      = vecs[i].we;
      dmem_req_wdata_i   = vecs[i].wd;
      dmem_req_wmask_i   = vecs[i].wm;
      mem_req_ready_i    = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_mem_valid", i), mem_req_valid_o, vecs[i].mv);
      check($sformatf("vec%0d_mem_addr", i), mem_req_addr_o, vecs[i].ma);
      check($sformatf("vec%0d_mem_we", i), mem_req_we_o, vecs[i].mwe);
      check($sformatf("vec%0d_mem_wdata", i), mem_req_wdata_o, vecs[i].mwd);
      check($sformatf("vec%0d_mem_wmask", i), mem_req_wmask_o, vecs[i].mwm);
      check($sformatf("vec%0d_if_ready", i), ifetch_req_ready_o, vecs[i].ifr);
      check($sformatf("vec%0d_d_ready", i), dmem_req_ready_o, vecs[i].dr);
      if (vecs[i].mv && vecs[i].rdy) begin
        step();
        clear_reqs();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h1000 + 32'(i);
        #1;
        check($sformatf("vec%0d_if_resp", i), ifetch_resp_valid_o, vecs[i].ifr);
        check($sformatf("vec%0d_d_resp", i), dmem_resp_valid_o, vecs[i].dr);
        if (vecs[i].dr)
          check($sformatf("vec%0d_d_data", i), dmem_resp_data_o, 32'h1000 + 32'(i));
        else
          check($sformatf("vec%0d_if_data", i), ifetch_resp_data_o, 32'h1000 + 32'(i));
        step();
        mem_resp_valid_i = 1'b0;
      end
      clear_reqs();
    end

    // Fetch only, memory latency of two cycles.
    step();
    mem_req_ready_i    = 1'b1;
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h100;
    #1;
    check("s1_if_ready", ifetch_req_ready_o, 1);
    check("s1_mem_valid", mem_req_valid_o, 1);
    check("s1_mem_addr", mem_req_addr_o, 32'h100);
    check("s1_d_ready", dmem_req_ready_o, 0);
    step();
    ifetch_req_valid_i = 1'b0;
    #1;
    check("s1_if_ready_pulse", ifetch_req_ready_o, 0);
    check("s1_no_reissue", mem_req_valid_o, 0);
    check("s1_no_early_resp", ifetch_resp_valid_o, 0);
    step();
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h00000013;
    #1;
    check("s1_if_resp", ifetch_resp_valid_o, 1);
    check("s1_if_data", ifetch_resp_data_o, 32'h00000013);
    check("s1_d_resp_quiet", dmem_resp_valid_o, 0);
    check("s1_d_data_quiet", dmem_resp_data_o, 0);
    step();
    mem_resp_valid_i = 1'b0;

    // Fetch and load together: load first, then fetch.
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h300;
    dmem_req_valid_i   = 1'b1;
    dmem_req_addr_i    = 32'h80;
    #1;
    check("s2_d_ready", dmem_req_ready_o, 1);
    check("s2_if_blocked", ifetch_req_ready_o, 0);
    check("s2_addr_load", mem_req_addr_o, 32'h80);
    step();
    dmem_req_valid_i = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h55;
    #1;
    check("s2_d_resp", dmem_resp_valid_o, 1);
    check("s2_d_data", dmem_resp_data_o, 32'h55);
    check("s2_if_resp_quiet", ifetch_resp_valid_o, 0);
    check("s2_no_req_in_resp", mem_req_valid_o, 0);
    step();
    mem_resp_valid_i = 1'b0;
    #1;
    check("s2_if_ready", ifetch_req_ready_o, 1);
    check("s2_addr_fetch", mem_req_addr_o, 32'h300);
    step();
    ifetch_req_valid_i = 1'b0;
    mem_resp_valid_i   = 1'b1;
    mem_resp_data_i    = 32'h66;
    #1;
    check("s2_if_resp", ifetch_resp_valid_o, 1);
    check("s2_if_data", ifetch_resp_data_o, 32'h66);
    check("s2_d_resp_quiet", dmem_resp_valid_o, 0);
    step();
    mem_resp_valid_i = 1'b0;

    // Starvation guard: four data grants, one fetch, and again.
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h400;
    dmem_req_valid_i   = 1'b1;
    dmem_req_addr_i    = 32'h1000;
    for (int k = 0; k < 10; k++) begin
      exp_fetch = (k == 4 || k == 9);
      #1;
      check($sformatf("s3_g%0d_valid", k), mem_req_valid_o, 1);
      check($sformatf("s3_g%0d_if_ready", k), ifetch_req_ready_o, exp_fetch);
      check($sformatf("s3_g%0d_d_ready", k), dmem_req_ready_o, !exp_fetch);
      check($sformatf("s3_g%0d_addr", k), mem_req_addr_o, exp_fetch ? 32'h400 : 32'h1000);
      step();
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 32'(k);
      #1;
      check($sformatf("s3_r%0d_if", k), ifetch_resp_valid_o, exp_fetch);
      check($sformatf("s3_r%0d_d", k), dmem_resp_valid_o, !exp_fetch);
      step();
      mem_resp_valid_i = 1'b0;
    end
    clear_reqs();

    // Flush while the fetch is outstanding drops its response.
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h200;
    #1;
    check("s4_if_ready", ifetch_req_ready_o, 1);
    step();
    ifetch_req_valid_i = 1'b0;
    ifetch_flush_i     = 1'b1;
    step();
    ifetch_flush_i = 1'b0;
    step();
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'hBAD;
    #1;
    check("s4_stale_dropped", ifetch_resp_valid_o, 0);
    step();
    mem_resp_valid_i   = 1'b0;
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h204;
    #1;
    check("s4_next_ready", ifetch_req_ready_o, 1);
    check("s4_next_addr", mem_req_addr_o, 32'h204);
    step();
    ifetch_req_valid_i = 1'b0;
    mem_resp_valid_i   = 1'b1;
    mem_resp_data_i    = 32'h93;
    #1;
    check("s4_next_resp", ifetch_resp_valid_o, 1);
    check("s4_next_data", ifetch_resp_data_o, 32'h93);
    step();
    mem_resp_valid_i = 1'b0;
    // Flush in the accept cycle marks the fetch stale.
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h208;
    ifetch_flush_i     = 1'b1;
    #1;
    check("s4_hs_flush_ready", ifetch_req_ready_o, 1);
    step();
    ifetch_req_valid_i = 1'b0;
    ifetch_flush_i     = 1'b0;
    mem_resp_valid_i   = 1'b1;
    mem_resp_data_i    = 32'h1;
    #1;
    check("s4_hs_flush_dropped", ifetch_resp_valid_o, 0);
    step();
    mem_resp_valid_i = 1'b0;
    // Flush in idle without a handshake is a no-op.
    ifetch_flush_i = 1'b1;
    #1;
    check("s4_idle_flush_no_req", mem_req_valid_o, 0);
    step();
    ifetch_flush_i     = 1'b0;
    ifetch_req_valid_i = 1'b1;
    ifetch_req_addr_i  = 32'h20C;
    #1;
    check("s4_after_idle_flush_ready", ifetch_req_ready_o, 1);
    step();
    ifetch_req_valid_i = 1'b0;
    mem_resp_valid_i   = 1'b1;
    mem_resp_data_i    = 32'h2;
    #1;
    check("s4_after_idle_flush_resp", ifetch_resp_valid_o, 1);
    check("s4_after_idle_flush_data", ifetch_resp_data_o, 32'h2);
    step();
    mem_resp_valid_i = 1'b0;

    // Store held off by memory for three cycles.
    mem_req_ready_i  = 1'b0;
    dmem_req_valid_i = 1'b1;
    dmem_req_addr_i  = 32'h40;
    dmem_req_we_i    = 1'b1;
    dmem_req_wdata_i = 32'hDEADBEEF;
    dmem_req_wmask_i = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("s5_c%0d_valid", c), mem_req_valid_o, 1);
      check($sformatf("s5_c%0d_addr", c), mem_req_addr_o, 32'h40);
      check($sformatf("s5_c%0d_we", c), mem_req_we_o, 1);
      check($sformatf("s5_c%0d_wdata", c), mem_req_wdata_o, 32'hDEADBEEF);
      check($sformatf("s5_c%0d_wmask", c), mem_req_wmask_o, 4'b0011);
      check($sformatf("s5_c%0d_d_ready", c), dmem_req_ready_o, 0);
      step();
    end
    mem_req_ready_i = 1'b1;
    #1;
    check("s5_hs_ready", dmem_req_ready_o, 1);
    check("s5_hs_valid", mem_req_valid_o, 1);
    step();
    clear_reqs();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h0;
    #1;
    check("s5_store_ack", dmem_resp_valid_o, 1);
    step();
    mem_resp_valid_i = 1'b0;

    // Reset while a load is outstanding.
    mem_req_ready_i  = 1'b1;
    dmem_req_valid_i = 1'b1;
    dmem_req_addr_i  = 32'h44;
    #1;
    check("s6_d_ready", dmem_req_ready_o, 1);
    step();
    dmem_req_valid_i = 1'b0;
    #1;
    check("s6_wait_no_req", mem_req_valid_o, 0);
    #1;
    reset_i            = 1'b1;
    mem_resp_valid_i   = 1'b1;
    mem_resp_data_i    = 32'h77;
    ifetch_req_valid_i = 1'b1;
    dmem_req_valid_i   = 1'b1;
    #1;
    check("s6_rst_d_resp", dmem_resp_valid_o, 0);
    check("s6_rst_d_data", dmem_resp_data_o, 0);
    check("s6_rst_if_resp", ifetch_resp_valid_o, 0);
    check("s6_rst_mem_valid", mem_req_valid_o, 0);
    check("s6_rst_if_ready", ifetch_req_ready_o, 0);
    check("s6_rst_d_ready", dmem_req_ready_o, 0);
    clear_reqs();
    step();
    reset_i = 1'b0;
    #1;
    check("s6_late_d_resp", dmem_resp_valid_o, 0);
    check("s6_late_if_resp", ifetch_resp_valid_o, 0);
    check("s6_late_d_data", dmem_resp_data_o, 0);
    step();
    mem_resp_valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the pipeline's instruction-fetch (IF) requester and its load/store (MEM) requester.
- Sits between the IF/MEM stages and the memory interface.
- Holds one transaction in flight, gives data accesses priority with a bounded fetch-starvation guard, and discards fetch responses that a control-hazard flush has made stale.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; wmask width = DATA_WIDTH/8
MAX_DATA_GRANTS, 4, consecutive data grants allowed while fetch waits (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
ifetch_req_valid_i  in  1  fetch request
ifetch_req_addr_i  in  ADDR_WIDTH  fetch address
ifetch_req_ready_o  out  1  fetch request accepted this cycle
ifetch_flush_i  in  1  drop any fetch in flight (control hazard)
ifetch_resp_valid_o  out  1  fetch data valid
ifetch_resp_data_o  out  DATA_WIDTH  fetched instruction
dmem_req_valid_i  in  1  data request
dmem_req_addr_i  in  ADDR_WIDTH  data address
dmem_req_we_i  in  1  1 = store
dmem_req_wdata_i  in  DATA_WIDTH  store data
dmem_req_wmask_i  in  DATA_WIDTH/8  byte enables
dmem_req_ready_o  out  1  data request accepted this cycle
dmem_resp_valid_o  out  1  load data / store ack
dmem_resp_data_o  out  DATA_WIDTH  load data
mem_req_valid_o  out  1  request to memory
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o / mem_req_we_o / mem_req_wdata_o / mem_req_wmask_o  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  muxed request fields
mem_resp_valid_i  in  1  response (read data or write ack)
mem_resp_data_i  in  DATA_WIDTH  read data

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- Reset: state=IDLE, starve_cnt=0, flushed=0. All valid/ready outputs are 0; data outputs are 0.
- States: IDLE, WAIT_IF, WAIT_D.
- IDLE grant selection (combinational):
  - Data is granted if dmem_req_valid_i && !(ifetch_req_valid_i && starve_cnt==MAX_DATA_GRANTS).
  - Otherwise fetch is granted if ifetch_req_valid_i.
  - Otherwise nothing is granted.
- IDLE outputs: mem_req_* = the granted requester's fields; mem_req_valid_o = any grant.
- Granted requester's ready_o = mem_req_ready_i (combinational). The other requester's ready_o = 0.
- Outside IDLE: both ready_o = 0 and mem_req_valid_o = 0.
- Handshake (mem_req_valid_o && mem_req_ready_i):
  - Data grant -> WAIT_D.
  - Fetch grant -> WAIT_IF.
- Starve counter, updated at data handshake:
  - Increments (saturating at MAX_DATA_GRANTS) if ifetch_req_valid_i=1.
  - Otherwise clears to 0.
  - Clears to 0 at fetch handshake.
- WAIT_D: on mem_resp_valid_i:
  - dmem_resp_valid_o=1 and dmem_resp_data_o=mem_resp_data_i in the same cycle.
  - Next state IDLE.
- WAIT_IF: on mem_resp_valid_i:
  - ifetch_resp_valid_o = !(flushed || ifetch_flush_i); data passed through.
  - Next state IDLE; flushed cleared.
- Flush:
  - ifetch_flush_i in WAIT_IF, or in the IDLE cycle of a fetch handshake, sets flushed.
  - ifetch_flush_i in IDLE without a fetch handshake has no effect.
  - Flush never cancels a request already accepted by memory.
- Latency:
  - Minimum request-to-response is 1 cycle after handshake.
  - No new request is issued in the response cycle; the next grant is earliest the following cycle.
  - Fully back-to-back throughput is therefore 1 transaction per 2 cycles.
- mem_resp_valid_i while in IDLE: ignored; no resp_valid_o is asserted.
- Simultaneous fetch and data request, starve_cnt < MAX: data wins; fetch ready_o = 0 and fetch must hold its request stable.
- mem_req_ready_i=0: outputs stay driven from the current IDLE grant. The grant may change if requester valids change, since requesters are not required to hold.
- Reset mid-transaction: return to IDLE immediately and drop the outstanding transaction. The memory side shares reset_i.
- Assertion: MAX_DATA_GRANTS >= 1 (elaboration check).

Decomposition:
- Shared package definitions holds:
  - arb_state_t enum {ARB_IDLE, ARB_WAIT_IF, ARB_WAIT_D}
  - mem_req_t struct {addr, we, wdata, wmask}, so the request mux is a single struct assignment
- No sub-module; the starvation counter is inline (a few lines).

Test Plan:
- Fetch only at 0x100, memory latency 2, resp 0x00000013: ifetch_req_ready_o pulses 1 cycle; ifetch_resp_valid_o=1 with 0x00000013 exactly 2 cycles after handshake; dmem_* outputs stay 0.
- Fetch and load both valid in IDLE, MAX_DATA_GRANTS=4: load granted first; fetch granted next in IDLE; responses routed to the correct port.
- Continuous data requests with fetch held valid, MAX=4: exactly 4 data grants, then 1 fetch grant; starve_cnt returns to 0 afterwards.
- Fetch accepted at 0x200, ifetch_flush_i pulsed 1 cycle later, resp arrives 3 cycles later: ifetch_resp_valid_o stays 0 and the next fetch response is delivered normally.
- Store addr 0x40, wdata 0xDEADBEEF, wmask 4'b0011 with mem_req_ready_i low for 3 cycles: mem_req_* are stable and ready_o=0 throughout; handshake on the ready cycle; dmem_resp_valid_o on ack.
- reset_i asserted in WAIT_D before response: all outputs go to 0 asynchronously; after release, a late mem_resp_valid_i produces no resp_valid_o.
